// File: rtl/csel_pkg.sv
`default_nettype none
// ============================================================================
// Package : csel_pkg
// Purpose : Shared definitions for the 5-way selector issue scheduler:
//           destination count, one-hot FSM state encodings, sticky error bit
//           indices and a small modulo-5 wrap helper for the round-robin
//           picker.
// Revision: 1.0 - initial release
// ============================================================================
package csel_pkg;

  localparam int NDEST = 5;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_DRIVE = 4'b0010,
    S_WAIT  = 4'b0100,
    S_ERR   = 4'b1000
  } state_e;

  localparam int ERR_TMO  = 0;
  localparam int ERR_OVF  = 1;
  localparam int ERR_SPUR = 2;

  // Reduce a value in 0..9 to 0..4 (sum of two indices each below NDEST).
  function automatic logic [2:0] wrap5(input logic [3:0] v);
    return (v >= 4'd5) ? 3'(v - 4'd5) : v[2:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/csel_credit_ctr.sv
`default_nettype none
// ============================================================================
// Module  : csel_credit_ctr
// Purpose : One destination's credit counter. Starts full at CREDITS,
//           decrements on dec_i, increments on ret_i; a same-cycle dec/ret
//           pair cancels. A return while already full saturates and raises
//           a 1-cycle ovf_o pulse.
// Ports   : clk, rstn (async active-low)
//           dec_i  - consume one credit (only asserted while nz_o is 1)
//           ret_i  - credit return pulse
//           nz_o   - counter is non-zero
//           ovf_o  - return arrived while already full (combinational)
// Revision: 1.0 - initial release
// ============================================================================
module csel_credit_ctr #(
  parameter int CREDITS  = 2,
  parameter int CREDIT_W = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic dec_i,
  input  logic ret_i,
  output logic nz_o,
  output logic ovf_o
);

  localparam logic [CREDIT_W-1:0] C_MAX = CREDIT_W'(CREDITS);

  logic [CREDIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_o = 1'b0;
    if (dec_i && !ret_i) begin
      // Guard against underflow even though the scheduler never asks for it.
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end else if (ret_i && !dec_i) begin
      if (cnt_q == C_MAX) ovf_o = 1'b1;
      else                cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= C_MAX;
    else       cnt_q <= cnt_d;
  end

  assign nz_o = (cnt_q != '0);

endmodule
`default_nettype wire

// File: rtl/csel5_dest_sched.sv
`default_nettype none
// ============================================================================
// Module  : csel5_dest_sched
// Purpose : Issue scheduler in front of the 5-way async selector. Accepts a
//           request (explicit mask or "any" = round-robin), checks credit,
//           registers {mask, payload} onto o_data, pulses o_drive for one
//           cycle and waits for i_free with a timeout.
// Ports   : clk, rstn (async active-low)
//           s_valid/s_ready/s_data/s_dest - request handshake
//           o_drive, o_data               - selector launch pulse and word
//           i_free                        - selector free pulse
//           i_credit_ret                  - per-destination credit returns
//           o_credit_nz, o_busy, o_err    - status and sticky errors
// Revision: 1.0 - initial release
// ============================================================================
module csel5_dest_sched
  import csel_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CREDITS    = 2,
  parameter int CREDIT_W   = 2,
  parameter int TIMEOUT    = 255,
  parameter int TMO_W      = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic [NDEST-1:0]        s_dest,
  output logic                    o_drive,
  output logic [DATA_WIDTH+4:0]   o_data,
  input  logic                    i_free,
  input  logic [NDEST-1:0]        i_credit_ret,
  output logic [NDEST-1:0]        o_credit_nz,
  output logic                    o_busy,
  output logic [2:0]              o_err
);

  state_e                  state_q, state_d;
  logic [2:0]              rr_ptr_q, rr_ptr_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic [DATA_WIDTH+4:0]   data_q, data_d;
  logic [2:0]              err_q, err_d;

  logic [NDEST-1:0]        credit_nz, credit_ovf, dec;
  logic [NDEST-1:0]        any_mask, mask;
  logic [2:0]              pick_idx, cand;
  logic                    pick_found, dest_any, eligible, accept;

  // Round-robin search: walk from the far end back toward rr_ptr so the last
  // hit written is the nearest destination with credit.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr_ptr_q;
    cand       = rr_ptr_q;
    for (int k = NDEST - 1; k >= 0; k--) begin
      cand = wrap5({1'b0, rr_ptr_q} + 4'(k));
      if (credit_nz[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign any_mask = pick_found ? (NDEST'(1) << pick_idx) : '0;
  assign dest_any = (s_dest == '0);
  assign mask     = dest_any ? any_mask : s_dest;
  // Multicast is all-or-none: every addressed destination needs credit.
  assign eligible = dest_any ? pick_found : ((s_dest & ~credit_nz) == '0);
  assign s_ready  = rstn & (state_q == S_IDLE) & eligible;
  assign accept   = s_valid & s_ready;
  assign dec      = accept ? mask : '0;

  for (genvar d = 0; d < NDEST; d++) begin : g_credit
    csel_credit_ctr #(
      .CREDITS  (CREDITS),
      .CREDIT_W (CREDIT_W)
    ) u_ctr (
      .clk   (clk),
      .rstn  (rstn),
      .dec_i (dec[d]),
      .ret_i (i_credit_ret[d]),
      .nz_o  (credit_nz[d]),
      .ovf_o (credit_ovf[d])
    );
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    tmo_d    = tmo_q;
    data_d   = data_q;
    err_d    = err_q;
    if (|credit_ovf) err_d[ERR_OVF] = 1'b1;
    if (i_free && (state_q != S_WAIT)) err_d[ERR_SPUR] = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_DRIVE;
          data_d  = {mask, s_data};
          if (dest_any) rr_ptr_d = wrap5({1'b0, pick_idx} + 4'd1);
        end
      end
      S_DRIVE: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tmo_d = tmo_q + 1'b1;
        // A free pulse on the timeout edge still completes the transaction.
        if (i_free) begin
          state_d = S_IDLE;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          state_d        = S_ERR;
          err_d[ERR_TMO] = 1'b1;
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      tmo_q    <= '0;
      data_q   <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      tmo_q    <= tmo_d;
      data_q   <= data_d;
      err_q    <= err_d;
    end
  end

  assign o_drive     = (state_q == S_DRIVE);
  assign o_busy      = (state_q != S_IDLE);
  assign o_data      = data_q;
  assign o_err       = err_q;
  assign o_credit_nz = credit_nz;

endmodule
`default_nettype wire

// File: tb/tb_csel5_dest_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_csel5_dest_sched
// Purpose : Directed self-checking bench for csel5_dest_sched. Expected
//           selector words are queued when a request is driven and compared
//           when o_drive pulses.
// Revision: 1.0 - initial release
// ============================================================================
module tb_csel5_dest_sched;

  localparam int TMO = 10;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic [4:0]  s_dest = '0;
  logic        o_drive;
  logic [36:0] o_data;
  logic        i_free = 1'b0;
  logic [4:0]  i_credit_ret = '0;
  logic [4:0]  o_credit_nz;
  logic        o_busy;
  logic [2:0]  o_err;

  int errors = 0;
  int checks = 0;
  logic [36:0] sb[$];

  always #5 clk = ~clk;

  csel5_dest_sched #(
    .DATA_WIDTH (32),
    .CREDITS    (2),
    .CREDIT_W   (2),
    .TIMEOUT    (TMO),
    .TMO_W      (4)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_dest       (s_dest),
    .o_drive      (o_drive),
    .o_data       (o_data),
    .i_free       (i_free),
    .i_credit_ret (i_credit_ret),
    .o_credit_nz  (o_credit_nz),
    .o_busy       (o_busy),
    .o_err        (o_err)
  );

  function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  // Scoreboard: every launch must match the oldest queued word.
  always @(negedge clk) begin
    if (rstn && o_drive) begin
      chk("drive_has_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) chk("o_data", 64'(o_data), 64'(sb.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [4:0] dest, input logic [31:0] data, input logic [4:0] exp_mask);
    @(negedge clk);
    s_valid = 1'b1; s_dest = dest; s_data = data;
    #1;
    chk("ready_before_accept", 64'(s_ready), 64'd1);
    sb.push_back({exp_mask, data});
    @(posedge clk); #1;
    s_valid = 1'b0; s_dest = '0;
    chk("drive_after_accept", 64'(o_drive), 64'd1);
  endtask

  task automatic free_after(input int n);
    repeat (n) @(negedge clk);
    i_free = 1'b1;
    @(negedge clk);
    i_free = 1'b0;
    chk("idle_after_free", 64'(o_busy), 64'd0);
  endtask

  task automatic ret(input logic [4:0] m);
    @(negedge clk);
    i_credit_ret = m;
    @(negedge clk);
    i_credit_ret = '0;
  endtask

  initial begin
    // Reset state, with a valid "any" request pending.
    s_valid = 1'b1; s_dest = '0;
    #12;
    chk("rst_drive", 64'(o_drive), 64'd0);
    chk("rst_data", 64'(o_data), 64'd0);
    chk("rst_err", 64'(o_err), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_nz", 64'(o_credit_nz), 64'h1f);
    chk("rst_ready", 64'(s_ready), 64'd0);
    s_valid = 1'b0;
    @(negedge clk); rstn = 1'b1;

    // Unicast to dest 2.
    send(5'b00100, 32'hA5A5_0001, 5'b00100);
    chk("busy_in_drive", 64'(o_busy), 64'd1);
    chk("nz_after_unicast", 64'(o_credit_nz), 64'h1f);
    free_after(4);
    s_dest = 5'b00100; #1;
    chk("ready_after_free", 64'(s_ready), 64'd1);
    s_dest = '0;
    ret(5'b00100);
    chk("err_after_ret", 64'(o_err), 64'd0);

    // Round-robin "any" requests.
    send(5'b00000, 32'h1111_0001, 5'b00001); free_after(2);
    send(5'b00000, 32'h1111_0002, 5'b00010); free_after(2);
    send(5'b00000, 32'h1111_0003, 5'b00100); free_after(2);
    send(5'b00000, 32'h1111_0004, 5'b01000); free_after(2);
    ret(5'b01111);
    chk("err_after_rr", 64'(o_err), 64'd0);

    // Credit exhaustion on dest 0.
    send(5'b00001, 32'h2222_0001, 5'b00001); free_after(2);
    send(5'b00001, 32'h2222_0002, 5'b00001); free_after(2);
    chk("nz_dest0_empty", 64'(o_credit_nz), 64'h1e);
    s_dest = 5'b00001; #1;
    chk("ready_no_credit", 64'(s_ready), 64'd0);
    s_dest = '0;
    send(5'b00000, 32'h2222_0003, 5'b10000); free_after(2);
    send(5'b00000, 32'h2222_0004, 5'b00010); free_after(2);
    @(negedge clk);
    s_dest = 5'b00001; i_credit_ret = 5'b00001; #1;
    chk("ready_before_ret", 64'(s_ready), 64'd0);
    @(negedge clk);
    i_credit_ret = '0; #1;
    chk("ready_after_ret", 64'(s_ready), 64'd1);
    s_dest = '0;

    // Multicast all-or-none.
    send(5'b00010, 32'h3333_0001, 5'b00010); free_after(2);
    chk("nz_dest1_empty", 64'(o_credit_nz), 64'h1d);
    @(negedge clk);
    s_valid = 1'b1; s_dest = 5'b00011; #1;
    chk("ready_multicast_blocked", 64'(s_ready), 64'd0);
    @(negedge clk);
    s_valid = 1'b0; s_dest = '0;
    chk("nz_multicast_unchanged", 64'(o_credit_nz), 64'h1d);
    send(5'b10100, 32'h3333_0002, 5'b10100); free_after(2);
    chk("nz_after_multicast", 64'(o_credit_nz), 64'h0d);

    // Accept to dest 3 with a simultaneous return to dest 3.
    @(negedge clk);
    s_valid = 1'b1; s_dest = 5'b01000; s_data = 32'h4444_0001; i_credit_ret = 5'b01000; #1;
    chk("ready_cancel", 64'(s_ready), 64'd1);
    sb.push_back({5'b01000, 32'h4444_0001});
    @(posedge clk); #1;
    s_valid = 1'b0; s_dest = '0; i_credit_ret = '0;
    chk("drive_cancel", 64'(o_drive), 64'd1);
    free_after(2);
    chk("err_after_cancel", 64'(o_err), 64'd0);
    send(5'b01000, 32'h4444_0002, 5'b01000); free_after(2);
    chk("nz3_after_one", 64'(o_credit_nz[3]), 64'd1);
    send(5'b01000, 32'h4444_0003, 5'b01000); free_after(2);
    chk("nz3_after_two", 64'(o_credit_nz[3]), 64'd0);

    // Credit overflow on dest 4.
    ret(5'b10000);
    ret(5'b10000);
    chk("err_full_no_ovf", 64'(o_err), 64'd0);
    ret(5'b10000);
    chk("err_ovf", 64'(o_err), 64'h2);

    // Spurious free in IDLE.
    @(negedge clk); i_free = 1'b1;
    @(negedge clk); i_free = 1'b0;
    chk("err_spur", 64'(o_err), 64'h6);
    chk("busy_after_spur", 64'(o_busy), 64'd0);

    // Free arriving on the timeout edge wins.
    send(5'b00100, 32'h5555_0001, 5'b00100);
    free_after(TMO + 1);
    chk("err_free_on_tmo_edge", 64'(o_err), 64'h6);

    // Real timeout.
    send(5'b00001, 32'h5555_0002, 5'b00001);
    repeat (TMO) @(negedge clk);
    chk("no_tmo_yet", 64'(o_err[0]), 64'd0);
    repeat (2) @(negedge clk);
    chk("err_tmo", 64'(o_err), 64'h7);
    chk("busy_in_err", 64'(o_busy), 64'd1);
    chk("drive_in_err", 64'(o_drive), 64'd0);
    s_valid = 1'b1; s_dest = '0; #1;
    chk("ready_in_err", 64'(s_ready), 64'd0);
    s_valid = 1'b0;

    // Leave ERR through reset.
    @(negedge clk); rstn = 1'b0;
    @(negedge clk); rstn = 1'b1;
    chk("err_cleared", 64'(o_err), 64'd0);
    chk("busy_cleared", 64'(o_busy), 64'd0);

    // Asynchronous reset in the middle of WAIT.
    send(5'b00010, 32'h6666_0001, 5'b00010);
    repeat (2) @(negedge clk);
    rstn = 1'b0; #1;
    chk("midrst_data", 64'(o_data), 64'd0);
    chk("midrst_nz", 64'(o_credit_nz), 64'h1f);
    chk("midrst_err", 64'(o_err), 64'd0);
    chk("midrst_busy", 64'(o_busy), 64'd0);
    @(negedge clk); rstn = 1'b1;

    // Round-robin pointer restarts at 0.
    send(5'b00000, 32'h7777_0001, 5'b00001); free_after(2);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
